// File: rtl/aurora_rx_block_demux.sv
// Aurora 64b/66b receive block demux: sync-header block lock with gearbox slip,
// per-block classification into data / user-K / control flags, and error count.
module aurora_rx_block_demux #(
    parameter int unsigned LOCK_COUNT = 64,
    parameter int unsigned WINDOW     = 1024,
    parameter int unsigned UNLOCK_ERR = 16,
    parameter int unsigned SLIP_WAIT  = 32
) (
    input  logic        Clk,
    input  logic        Rst_b,
    input  logic [65:0] AuroraBlock,
    input  logic        BlockValid,
    output logic        Slip,
    output logic        BlockLock,
    output logic [63:0] Data,
    output logic [3:0]  DataBytes,
    output logic        DataValid,
    output logic        DataEnd,
    output logic [63:0] UserK,
    output logic        UserKValid,
    output logic [5:0]  RxFlags,
    output logic [15:0] ErrCount
);

    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned WW = $clog2(WINDOW + 1);
    localparam int unsigned BW = $clog2(UNLOCK_ERR + 1);
    localparam int unsigned SW = $clog2(SLIP_WAIT + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_ERR - 1);
    localparam logic [SW-1:0] SLIP_LAST = SW'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKING,
        ST_SLIPWAIT,
        ST_LOCKED
    } state_t;

    state_t        state;
    logic [GW-1:0] good_cnt;
    logic [WW-1:0] win_cnt;
    logic [BW-1:0] bad_cnt;
    logic [SW-1:0] slip_cnt;

    logic [1:0]  hdr;
    logic [7:0]  btype;
    logic [2:0]  sep_cnt;
    logic        hdr_ok;
    logic [63:0] sep_data;
    logic [63:0] dec_data;
    logic [3:0]  dec_bytes;
    logic        dec_dv;
    logic        dec_end;
    logic        dec_ukv;
    logic [5:0]  dec_flags;
    logic        dec_err;
    logic        err_event;

    assign hdr     = AuroraBlock[65:64];
    assign btype   = AuroraBlock[63:56];
    assign sep_cnt = AuroraBlock[50:48];
    assign hdr_ok  = (hdr == 2'b01) || (hdr == 2'b10);

    always_comb begin
        sep_data  = '0;
        dec_data  = '0;
        dec_bytes = '0;
        dec_dv    = 1'b0;
        dec_end   = 1'b0;
        dec_ukv   = 1'b0;
        dec_flags = '0;
        dec_err   = 1'b0;
        // SEP bytes beyond the count are masked so the unused tail reads as zero
        for (int unsigned i = 0; i < 6; i++) begin
            if (i < {29'd0, sep_cnt}) begin
                sep_data[63-8*i -: 8] = AuroraBlock[47-8*i -: 8];
            end
        end
        if (hdr == 2'b01) begin
            dec_data  = AuroraBlock[63:0];
            dec_bytes = 4'd8;
            dec_dv    = 1'b1;
        end else if (hdr == 2'b10) begin
            case (btype)
                8'h78: dec_flags[3:0] = AuroraBlock[55:52];
                8'hAA: dec_flags[4]   = 1'b1;
                8'h2D: dec_flags[5]   = 1'b1;
                8'h1E: begin
                    if (sep_cnt == 3'd7 || AuroraBlock[55:51] != 5'd0) begin
                        dec_err = 1'b1;
                    end else begin
                        dec_data  = sep_data;
                        dec_bytes = {1'b0, sep_cnt};
                        dec_dv    = 1'b1;
                        dec_end   = 1'b1;
                    end
                end
                8'hE1: begin
                    dec_data  = {AuroraBlock[55:0], 8'h00};
                    dec_bytes = 4'd7;
                    dec_dv    = 1'b1;
                    dec_end   = 1'b1;
                end
                8'hD2, 8'h99, 8'h55, 8'hB4, 8'hCC,
                8'h66, 8'h33, 8'h4B, 8'h87: dec_ukv = 1'b1;
                default: dec_err = 1'b1;
            endcase
        end
    end

    assign err_event = !hdr_ok || (state == ST_LOCKED && dec_err);

    always_ff @(posedge Clk or negedge Rst_b) begin
        if (!Rst_b) begin
            state      <= ST_UNLOCKED;
            good_cnt   <= '0;
            win_cnt    <= '0;
            bad_cnt    <= '0;
            slip_cnt   <= '0;
            Slip       <= 1'b0;
            BlockLock  <= 1'b0;
            Data       <= '0;
            DataBytes  <= '0;
            DataValid  <= 1'b0;
            DataEnd    <= 1'b0;
            UserK      <= '0;
            UserKValid <= 1'b0;
            RxFlags    <= '0;
            ErrCount   <= '0;
        end else begin
            Slip       <= 1'b0;
            DataValid  <= 1'b0;
            DataEnd    <= 1'b0;
            UserKValid <= 1'b0;
            RxFlags    <= '0;
            if (BlockValid) begin
                if (err_event && ErrCount != '1) begin
                    ErrCount <= ErrCount + 16'd1;
                end
                case (state)
                    // The first block after unlock already counts toward lock
                    ST_UNLOCKED: begin
                        state    <= ST_LOCKING;
                        good_cnt <= hdr_ok ? GW'(1) : '0;
                    end
                    ST_LOCKING: begin
                        if (!hdr_ok) begin
                            Slip     <= 1'b1;
                            good_cnt <= '0;
                            slip_cnt <= '0;
                            state    <= ST_SLIPWAIT;
                        end else if (good_cnt == GOOD_LAST) begin
                            good_cnt  <= '0;
                            win_cnt   <= '0;
                            bad_cnt   <= '0;
                            BlockLock <= 1'b1;
                            state     <= ST_LOCKED;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    ST_SLIPWAIT: begin
                        if (slip_cnt == SLIP_LAST) begin
                            slip_cnt <= '0;
                            good_cnt <= '0;
                            state    <= ST_LOCKING;
                        end else begin
                            slip_cnt <= slip_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (!hdr_ok && bad_cnt == BAD_LAST) begin
                            BlockLock <= 1'b0;
                            good_cnt  <= '0;
                            state     <= ST_UNLOCKED;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                            if (!hdr_ok) begin
                                bad_cnt <= bad_cnt + 1'b1;
                            end
                        end
                        if (dec_dv) begin
                            Data      <= dec_data;
                            DataBytes <= dec_bytes;
                            DataValid <= 1'b1;
                            DataEnd   <= dec_end;
                        end
                        if (dec_ukv) begin
                            UserK      <= AuroraBlock[63:0];
                            UserKValid <= 1'b1;
                        end
                        RxFlags <= dec_flags;
                    end
                    default: state <= ST_UNLOCKED;
                endcase
            end
        end
    end

endmodule

// File: doc/aurora_rx_block_demux.md
Name: aurora_rx_block_demux

Overview:
- Receive-side counterpart of the Aurora 64b/66b TX priority mux.
- Accepts 66-bit blocks from the RX gearbox.
- Runs a sync-header block-lock state machine and drives a slip request back to the gearbox.
- Once locked, classifies each block and presents one registered output per block: user data (full/SEP/SEP7), user-K payload, or control flags (CC/NR/CB/NFC/UFC/idle). Also keeps a saturating error counter.

Parameters:
- LOCK_COUNT, 64: consecutive valid sync headers needed to declare lock.
- WINDOW, 1024: blocks per error-monitoring window while locked.
- UNLOCK_ERR, 16: header errors within one window that force loss of lock.
- SLIP_WAIT, 32: BlockValid cycles ignored after a Slip pulse.

Ports:
- Clk  in  1  block clock.
- Rst_b  in  1  asynchronous active-low reset.
- AuroraBlock  in  66  [65:64] sync header, [63:56] block type, [55:0] payload.
- BlockValid  in  1  AuroraBlock valid this cycle.
- Slip  out  1  one-cycle request to gearbox to shift alignment by one bit.
- BlockLock  out  1  high in LOCKED.
- Data  out  64  user data; SEP/SEP7 bytes are left-aligned at [63:...], remaining bits are zero.
- DataBytes  out  4  valid bytes in Data: 8 for full, 0-6 for SEP, 7 for SEP7.
- DataValid  out  1  Data/DataBytes valid.
- DataEnd  out  1  qualifies DataValid; marks SEP/SEP7 (end of frame).
- UserK  out  64  block type and 56-bit payload of a user-K block.
- UserKValid  out  1  UserK valid.
- RxFlags  out  6  one-cycle pulses: [0] idle, [1] NR, [2] CB, [3] CC, [4] NFC, [5] UFC.
- ErrCount  out  16  saturating count of header and decode errors.

Behaviour:
- Reset (async assert, sync release): state UNLOCKED; all outputs 0; all counters 0.
- Latency: every classification output is registered, 1 Clk after the BlockValid cycle. Valid/flag outputs are single-cycle pulses. Data, UserK and DataBytes hold their last value.
- A header is valid if it is 2'b01 or 2'b10. A header of 2'b00 or 2'b11 is an error.
- Lock FSM, advancing only on BlockValid:
  - UNLOCKED: go to LOCKING on the next BlockValid; clear the good counter.
  - LOCKING:
    - Valid header: good counter +1. When it reaches LOCK_COUNT, go to LOCKED and clear the window counters.
    - Invalid header: Slip=1 for one cycle, clear the good counter, enter SLIPWAIT.
  - SLIPWAIT: count SLIP_WAIT BlockValid cycles, then return to LOCKING.
  - LOCKED:
    - Window counter +1 per block; error counter +1 per invalid header.
    - Error counter reaching UNLOCK_ERR → UNLOCKED, BlockLock=0 the next cycle.
    - Window counter reaching WINDOW → clear both counters.
    - Simultaneous window end and UNLOCK_ERR-th error: unlock takes priority.
- Decode is active only in LOCKED; outside LOCKED, no valid or flag outputs are produced.
  - Header 01: Data=block[63:0], DataBytes=8, DataValid=1, DataEnd=0.
  - Header 10, type 0x78 (idle-family): byte [55:48] bit4→idle, bit5→NR, bit6→CB, bit7→CC. Several bits may be set together; all corresponding flags pulse.
  - Type 0xAA → RxFlags[4]. Type 0x2D → RxFlags[5].
  - Type 0x1E (SEP):
    - Count = [50:48]. Counts 0-6: Data={[47:0] bytes, zero pad}, DataBytes=count, DataValid=1, DataEnd=1.
    - Count 0 is still DataValid with DataBytes=0.
    - Count 7, or [55:51] nonzero: decode error, no output.
  - Type 0xE1 (SEP7): Data={[55:0],8'h0}, DataBytes=7, DataValid=1, DataEnd=1.
  - Types 0xD2,0x99,0x55,0xB4,0xCC,0x66,0x33,0x4B,0x87: UserK=block[63:0], UserKValid=1.
  - Any other type: decode error.
- ErrCount: +1 per invalid header in any state and per decode error. Saturates at 16'hFFFF and never wraps.
- BlockValid=0: no state change, no pulses.
- Reset asserted mid-frame: immediate return to UNLOCKED and all outputs 0.

Test Plan:
- Reset, then 64 valid 2'b01 blocks → BlockLock=1 one cycle after the 64th. Before that, DataValid=0 throughout.
- 10 good headers, one 2'b11, then good headers → Slip pulses once, ErrCount=1. The next 32 BlockValids are ignored, then 64 good headers → lock.
- Locked; send 66'h1_0123456789ABCDEF → Data=64'h0123456789ABCDEF, DataBytes=8, DataEnd=0. Send SEP with count 3 and payload 48'hAABBCC000000 → Data=64'hAABBCC0000000000, DataBytes=3, DataEnd=1.
- Locked; send control 0x78 with byte 0xC0 → RxFlags=6'b001100 for one cycle. Send type 0xD2 → UserKValid=1, UserK[63:56]=8'hD2.
- Locked; 16 bad headers within 1000 blocks → BlockLock=0, ErrCount=16. With 15 bad headers per window over 3 windows → lock held.
- Locked; SEP with count 7 → no DataValid, ErrCount +1. Force ErrCount to 16'hFFFF, then inject an error → stays at 16'hFFFF.
